// File: rtl/quadrature_decoder.sv
// Quadrature decoder front end for the up/down counter.
// Synchronizes and glitch-filters encoder channels A/B, tracks the Gray-code
// position, and emits one-cycle step pulses with direction plus an
// illegal-transition pulse and a saturating error counter.
//
// Output protocol: counter_on and err are single-cycle pulses with no
// back-pressure. counter_on marks a legal step, and count_up (held between
// steps) gives its direction. err marks a double-edge transition.
// counter_on and err are never high together.
module quadrature_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             chan_a,
  input  logic             chan_b,
  input  logic             clear_err,
  output logic             counter_on,
  output logic             count_up,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       ab_state
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  // Counter value on which one more differing sample completes the filter run.
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

  // Gray-code positions of the filtered {A,B} pair.
  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_01 = 2'b01,
    AB_10 = 2'b10,
    AB_11 = 2'b11
  } ab_e;

  logic [SYNC_STAGES-1:0]  sync_a_q;
  logic [SYNC_STAGES-1:0]  sync_b_q;
  logic [1:0]              sync_out;
  logic [1:0][CNT_W-1:0]   filt_cnt_q;
  logic [1:0][CNT_W-1:0]   filt_cnt_d;
  logic [1:0]              filt_q;
  logic [1:0]              filt_d;
  ab_e                     prev_q;
  ab_e                     cur_state;
  logic                    step_fwd;
  logic                    step_rev;
  logic                    step_bad;
  logic                    counter_on_q;
  logic                    count_up_q;
  logic                    err_q;
  logic [ERR_W-1:0]        err_count_q;

  // Forward rotation order: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic ab_e fwd_next(input ab_e s);
    case (s)
      AB_00:   fwd_next = AB_01;
      AB_01:   fwd_next = AB_11;
      AB_11:   fwd_next = AB_10;
      default: fwd_next = AB_00;
    endcase
  endfunction

  // Synchronizer chains; only the last stage feeds the filter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], chan_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], chan_b};
    end
  end

  assign sync_out = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  // Per-channel run-length filter; bypassed while decoding is disabled.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (!enable) begin
        filt_d[i] = sync_out[i];
      end else if (sync_out[i] != filt_q[i]) begin
        if (filt_cnt_q[i] == FILT_LAST) begin
          filt_d[i] = sync_out[i];
        end else begin
          filt_cnt_d[i] = filt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= '0;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Step classification between the previous and current filtered state.
  always_comb begin
    cur_state = ab_e'(filt_q);
    step_fwd  = (cur_state == fwd_next(prev_q));
    step_rev  = (prev_q == fwd_next(cur_state));
    step_bad  = ((filt_q ^ prev_q) == 2'b11);
  end

  // Gray-code tracker with registered pulse, direction and error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q       <= AB_00;
      counter_on_q <= 1'b0;
      count_up_q   <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      prev_q       <= cur_state;
      counter_on_q <= enable && (step_fwd || step_rev);
      err_q        <= enable && step_bad;
      if (enable && (step_fwd || step_rev)) begin
        count_up_q <= step_fwd;
      end
      // Clear wins over a simultaneous illegal step; the err pulse still fires.
      if (clear_err) begin
        err_count_q <= '0;
      end else if (enable && step_bad && (err_count_q != '1)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign counter_on = counter_on_q;
  assign count_up   = count_up_q;
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign ab_state   = filt_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Testbench for quadrature_decoder: drives encoder sequences and checks
// every pulse against an expected-event queue filled as stimulus is driven.
module tb_quadrature_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int ERR_W       = 8;
  localparam int LAT         = SYNC_STAGES + FILTER_LEN + 1;

  localparam logic [1:0] EV_REV = 2'd0;
  localparam logic [1:0] EV_FWD = 2'd1;
  localparam logic [1:0] EV_ERR = 2'd2;

  // Clock / reset block
  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             chan_a;
  logic             chan_b;
  logic             clear_err;
  logic             counter_on;
  logic             count_up;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       ab_state;

  always #5 clk = ~clk;

  quadrature_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .ERR_W      (ERR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .chan_a    (chan_a),
    .chan_b    (chan_b),
    .clear_err (clear_err),
    .counter_on(counter_on),
    .count_up  (count_up),
    .err       (err),
    .err_count (err_count),
    .ab_state  (ab_state)
  );

  int         tests_run = 0;
  int         fail_cnt  = 0;
  int         cyc       = 0;
  int         pulse_cyc = -1;
  logic [1:0] exp_q[$];
  logic [1:0] model_ab;
  logic [1:0] mon_got;
  logic [1:0] mon_exp;
  logic [1:0] fwd_tbl[4] = '{2'b01, 2'b11, 2'b00, 2'b10};

  always @(posedge clk) cyc++;

  // Scoreboard: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (counter_on || err) begin
      mon_got = err ? EV_ERR : (count_up ? EV_FWD : EV_REV);
      tests_run++;
      if (counter_on && err) begin
        fail_cnt++;
        $display("FAIL pulse_overlap: counter_on=%b err=%b, required only one high at cycle %0d", counter_on, err, cyc);
      end else if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL unexpected_pulse: event=%0d at cycle %0d, required no pulse", mon_got, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          fail_cnt++;
          $display("FAIL pulse_kind: event=%0d, required %0d at cycle %0d", mon_got, mon_exp, cyc);
        end
      end
      if (counter_on) pulse_cyc = cyc;
    end
  end

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ab(input logic [1:0] ab, input int hold);
    chan_a = ab[1];
    chan_b = ab[0];
    if (enable && (ab != model_ab)) begin
      if ((ab ^ model_ab) == 2'b11)       exp_q.push_back(EV_ERR);
      else if (fwd_tbl[model_ab] == ab)   exp_q.push_back(EV_FWD);
      else                                exp_q.push_back(EV_REV);
    end
    model_ab = ab;
    wait_cyc(hold);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    clear_err = 1'b0;
    chan_a    = 1'b0;
    chan_b    = 1'b0;
    model_ab  = 2'b00;
    wait_cyc(3);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic check_drain(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL %s_missing_pulses: %0d outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    chan_a = 1'b1; chan_b = 1'b1; enable = 1'b1; clear_err = 1'b0;
    reset = 1'b1;
    wait_cyc(4);
    tests_run++;
    if ({counter_on, count_up, err, err_count, ab_state} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: on=%b up=%b err=%b cnt=%0d ab=%b, required all 0", counter_on, count_up, err, err_count, ab_state);
    end
    do_reset();
  endtask

  task automatic test_forward();
    int t0;
    enable = 1'b1;
    wait_cyc(3);
    t0 = cyc;
    drive_ab(2'b01, 10);
    tests_run++;
    if (pulse_cyc !== t0 + LAT) begin
      fail_cnt++;
      $display("FAIL fwd_latency: pulse %0d edges after change, required %0d", pulse_cyc - t0, LAT);
    end
    drive_ab(2'b11, $urandom_range(7, 12));
    drive_ab(2'b10, $urandom_range(7, 12));
    tests_run++;
    if (ab_state !== 2'b10) begin
      fail_cnt++;
      $display("FAIL fwd_ab_state: ab=%b, required 10", ab_state);
    end
    drive_ab(2'b00, 10);
    tests_run++;
    if (count_up !== 1'b1) begin
      fail_cnt++;
      $display("FAIL fwd_count_up: count_up=%b, required 1", count_up);
    end
    check_drain("forward");
  endtask

  task automatic test_reverse();
    logic [1:0] seq[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive_ab(seq[i], $urandom_range(7, 12));
      tests_run++;
      if (ab_state !== seq[i]) begin
        fail_cnt++;
        $display("FAIL rev_ab_state_%0d: ab=%b, required %b", i, ab_state, seq[i]);
      end
    end
    tests_run++;
    if (count_up !== 1'b0) begin
      fail_cnt++;
      $display("FAIL rev_count_up: count_up=%b, required 0", count_up);
    end
    check_drain("reverse");
  endtask

  task automatic test_glitch();
    drive_ab(2'b01, 10);
    check_drain("glitch_setup");
    chan_a = 1'b1;
    wait_cyc(FILTER_LEN - 1);
    chan_a = 1'b0;
    wait_cyc(12);
    tests_run++;
    if (ab_state !== 2'b01) begin
      fail_cnt++;
      $display("FAIL glitch_ab_state: ab=%b, required 01", ab_state);
    end
    check_drain("glitch_short");
    exp_q.push_back(EV_FWD);
    exp_q.push_back(EV_REV);
    chan_a = 1'b1;
    wait_cyc(FILTER_LEN);
    chan_a = 1'b0;
    wait_cyc(15);
    check_drain("glitch_long");
  endtask

  task automatic test_illegal();
    do_reset();
    enable = 1'b1;
    wait_cyc(3);
    drive_ab(2'b11, 10);
    tests_run++;
    if (err_count !== 8'd1) begin
      fail_cnt++;
      $display("FAIL illegal_count: err_count=%0d, required 1", err_count);
    end
    drive_ab(2'b10, 10);
    check_drain("illegal_then_fwd");
    for (int i = 0; i < 260; i++) begin
      drive_ab((i % 2 == 0) ? 2'b01 : 2'b10, 6);
    end
    wait_cyc(10);
    check_drain("illegal_flood");
    tests_run++;
    if (err_count !== 8'hFF) begin
      fail_cnt++;
      $display("FAIL illegal_saturate: err_count=%0d, required 255", err_count);
    end
  endtask

  task automatic test_clear();
    int waited;
    clear_err = 1'b1;
    wait_cyc(1);
    clear_err = 1'b0;
    tests_run++;
    if (err_count !== 8'd0) begin
      fail_cnt++;
      $display("FAIL clear_plain: err_count=%0d, required 0", err_count);
    end
    drive_ab(2'b01, 10);
    drive_ab(2'b10, 10);
    drive_ab(2'b01, 10);
    tests_run++;
    if (err_count !== 8'd3) begin
      fail_cnt++;
      $display("FAIL clear_recount: err_count=%0d, required 3", err_count);
    end
    clear_err = 1'b1;
    drive_ab(2'b10, 0);
    waited = 0;
    while (!err && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (!err) begin
      fail_cnt++;
      $display("FAIL clear_err_timeout: err=%b after %0d cycles, required 1", err, waited);
    end else if (err_count !== 8'd0) begin
      fail_cnt++;
      $display("FAIL clear_wins: err_count=%0d, required 0", err_count);
    end
    clear_err = 1'b0;
    wait_cyc(10);
    check_drain("clear");
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    drive_ab(2'b00, 5);
    drive_ab(2'b01, 6);
    drive_ab(2'b11, 6);
    tests_run++;
    if (ab_state !== 2'b11) begin
      fail_cnt++;
      $display("FAIL enable_track: ab=%b, required 11", ab_state);
    end
    enable = 1'b1;
    wait_cyc(10);
    check_drain("enable_raise");
    drive_ab(2'b10, 10);
    check_drain("enable_step");
    tests_run++;
    if (count_up !== 1'b1) begin
      fail_cnt++;
      $display("FAIL enable_count_up: count_up=%b, required 1", count_up);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1;
    wait_cyc(3);
    drive_ab(2'b01, FILTER_LEN + 1);
    drive_ab(2'b11, FILTER_LEN + 1);
    drive_ab(2'b10, FILTER_LEN + 1);
    drive_ab(2'b00, FILTER_LEN + 1);
    wait_cyc(10);
    check_drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    wait_cyc(3);
    drive_ab(2'b01, 10);
    drive_ab(2'b11, 10);
    drive_ab(2'b00, 10);
    drive_ab(2'b01, 10);
    drive_ab(2'b11, 10);
    drive_ab(2'b10, 10);
    check_drain("reset_mid_setup");
    tests_run++;
    if (count_up !== 1'b1 || err_count !== 8'd1) begin
      fail_cnt++;
      $display("FAIL reset_mid_pre: up=%b cnt=%0d, required up=1 cnt=1", count_up, err_count);
    end
    // 10 -> 00 is in flight; reset lands on the edge that would pulse.
    chan_a = 1'b0;
    chan_b = 1'b0;
    model_ab = 2'b00;
    wait_cyc(LAT - 1);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({counter_on, count_up, err, err_count, ab_state} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_mid_outputs: on=%b up=%b err=%b cnt=%0d ab=%b, required all 0", counter_on, count_up, err, err_count, ab_state);
    end
    reset = 1'b0;
    wait_cyc(15);
    check_drain("reset_mid_after");
  endtask

  initial begin
    #5ms;
    fail_cnt++;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; clear_err = 1'b0; chan_a = 1'b0; chan_b = 1'b0;
    model_ab = 2'b00;
    @(negedge clk);
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_clear();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
Front end for the up/down counter. It converts the two phase-shifted channels (A, B) from an incremental shaft encoder into the counter's control pair: a one-cycle count_on enable and a count_up direction. It synchronizes and glitch-filters both pins, then runs a 4-state Gray-code tracker. It flags illegal double-edge transitions with a pulse and a saturating error count.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per channel; legal values 2..4.
FILTER_LEN, 4, consecutive differing samples required before the filtered level changes; legal values 1..15.
ERR_W, 8, width of the saturating illegal-transition counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high; clears all state.
enable  input  1  1 = decode; 0 = track pins silently, with no pulses and no errors.
chan_a  input  1  encoder channel A, asynchronous.
chan_b  input  1  encoder channel B, asynchronous.
clear_err  input  1  synchronous clear of err_count.
counter_on  output  1  one-cycle pulse for each legal quadrature step.
count_up  output  1  direction of the last legal step; 1 = forward.
err  output  1  one-cycle pulse for each illegal transition.
err_count  output  ERR_W  illegal transitions since the last reset or clear; saturates at all-ones.
ab_state  output  2  filtered {A,B}.

Behaviour:
- Reset:
  - Affects synchronizer flops, filter counters, filtered levels, prev_state, counter_on, count_up, err and err_count.
  - All of these go to 0 at the reset edge.
  - Reset takes priority over every other input.
  - Asserted mid-operation, it kills any pulse at that edge.
- Synchronizer: each channel passes through a chain of SYNC_STAGES flops; only the last stage is used downstream.
- Filter (per channel, one filtered level and a counter of $clog2(FILTER_LEN+1) bits):
  - Sync output equal to filtered level: the counter clears.
  - Sync output differs: the counter increments.
  - The filtered level takes the new value on the edge where the counter would reach FILTER_LEN; the counter then clears.
  - FILTER_LEN=1 means the filtered level follows the sync output one cycle later.
- Decoder:
  - prev_state is registered from {A_f,B_f} every cycle.
  - The step is evaluated as prev_state -> current {A_f,B_f}.
- Step classification:
  - Forward: 00->01->11->10->00. Result: counter_on=1 and count_up=1 on the next edge.
  - Reverse: 00->10->11->01->00. Result: counter_on=1 and count_up=0 on the next edge.
  - No change: counter_on=0; count_up holds.
  - Both bits changed (illegal): counter_on=0 and count_up holds. err=1 for one cycle. err_count increments unless it is already all-ones. The new state is accepted as the reference; no resync delay.
- Latency: a clean level change on one pin produces a counter_on pulse SYNC_STAGES+FILTER_LEN+1 edges after the first edge that samples the new level (7 edges at defaults).
- enable=0:
  - Filtered levels load the sync outputs directly every cycle, bypassing the filter.
  - prev_state tracks, counter_on=0 and err=0, so raising enable never yields a spurious step.
  - Filter counters are held at 0.
- clear_err: err_count goes to 0 on the next edge. If an illegal step occurs on the same edge, clear wins (count=0) but the err pulse is still produced.
- Maximum step rate: one step per FILTER_LEN+1 cycles; faster inputs are filtered out.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Forward rotation: reset, enable=1, drive AB 00,01,11,10,00, each held 10 cycles → 4 counter_on pulses with count_up=1. The first pulse arrives exactly 7 edges after the 00->01 sample edge.
- Reverse rotation: drive AB 00,10,11,01,00, each held 10 cycles → 4 pulses with count_up=0. ab_state follows the sequence.
- Glitch rejection: with A steady at 0, pulse A high for 3 cycles (FILTER_LEN=4) → no counter_on and ab_state unchanged. A 4-cycle pulse → one forward step, then one reverse step on return.
- Illegal step: from AB=00 (enable=1), change to 11 in the same cycle → err pulses once, no counter_on, err_count=1. A following 11->10 gives a legal forward pulse. Driving 255+ illegal steps (ERR_W=8) leaves err_count=255.
- Enable gating: with enable=0, toggle AB through 00,01,11 → no pulses and ab_state=11. Raise enable with pins steady → no pulse. A later 11->10 gives a forward pulse.
- Reset and clear: with err_count=3, assert clear_err together with an illegal step → err=1 and err_count=0. Assert reset mid-rotation → all outputs 0 on that edge and no pulse is emitted for the in-flight transition.
